// File: rtl/symm_decorr4.sv
// One step of FastICA symmetric orthogonalisation: W' = 1.5*W - 0.5*G*W, one element per cycle.
// Optional macro SYMM_DECORR4_SAT_EN: saturating output format plus a sat_flag output; default wraps.
module symm_decorr4 #(
    parameter int WIDTH = 26,
    parameter int FRAC  = 13
) (
    input  logic                  clk_dec4,
    input  logic                  rst_dec4,
    input  logic                  start,
    input  logic [16*WIDTH-1:0]   w_in,
    input  logic [16*WIDTH-1:0]   g_in,
    output logic                  busy,
    output logic                  done,
`ifdef SYMM_DECORR4_SAT_EN
    output logic                  sat_flag,
`endif
    output logic [16*WIDTH-1:0]   w_out
);

    localparam int SW = 2*WIDTH + 2;
    localparam int RW = SW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

    state_t                   state_reg, state_next;
    logic [3:0]               k_reg;
    logic signed [WIDTH-1:0]  w_reg [16];
    logic signed [WIDTH-1:0]  g_reg [16];
    logic signed [WIDTH-1:0]  r_reg [15];
    logic [16*WIDTH-1:0]      w_out_reg;
    logic [16*WIDTH-1:0]      r_packed;

    logic signed [2*WIDTH-1:0] prod [4];
    logic signed [SW-1:0]      prod_ext [4];
    logic signed [SW-1:0]      s_sum;
    logic signed [SW-1:0]      t_shift;
    logic signed [WIDTH-1:0]   w_cur;
    logic signed [RW-1:0]      w_ext;
    logic signed [RW-1:0]      three_w;
    logic signed [RW-1:0]      diff;
    logic signed [WIDTH-1:0]   r_fmt;

    // Row i = k[3:2] of G against column j = k[1:0] of W, four products in parallel
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mac
            assign prod[gi]     = g_reg[{k_reg[3:2], 2'(gi)}] * w_reg[{2'(gi), k_reg[1:0]}];
            assign prod_ext[gi] = {{2{prod[gi][2*WIDTH-1]}}, prod[gi]};
        end
    endgenerate

    assign s_sum   = prod_ext[0] + prod_ext[1] + prod_ext[2] + prod_ext[3];
    assign t_shift = s_sum >>> FRAC;
    assign w_cur   = w_reg[k_reg];
    assign w_ext   = {{(RW-WIDTH){w_cur[WIDTH-1]}}, w_cur};
    assign three_w = w_ext + (w_ext <<< 1);
    assign diff    = three_w - {t_shift[SW-1], t_shift};

`ifdef SYMM_DECORR4_SAT_EN
    logic signed [RW-1:0]     r_full;
    logic [RW-WIDTH:0]        r_hi;
    logic                     clip;
    logic                     clip_acc_reg;
    logic                     sat_flag_reg;

    assign r_full = diff >>> 1;
    assign r_hi   = r_full[RW-1:WIDTH-1];
    assign clip   = ~((&r_hi) | ~(|r_hi));
    assign r_fmt  = clip ? (r_full[RW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                         : r_full[WIDTH-1:0];
    assign sat_flag = sat_flag_reg;

    always_ff @(posedge clk_dec4) begin
        if (rst_dec4) begin
            clip_acc_reg <= 1'b0;
            sat_flag_reg <= 1'b0;
        end else if (state_reg == LOAD) begin
            clip_acc_reg <= 1'b0;
            sat_flag_reg <= 1'b0;
        end else if (state_reg == CALC) begin
            clip_acc_reg <= clip_acc_reg | clip;
            if (k_reg == 4'd15)
                sat_flag_reg <= clip_acc_reg | clip;
        end
    end
`else
    assign r_fmt = WIDTH'(diff >>> 1);
`endif

    // The last element bypasses r_reg so the whole matrix is visible in the DONE cycle
    generate
        for (gi = 0; gi < 15; gi++) begin : g_pack
            assign r_packed[gi*WIDTH +: WIDTH] = r_reg[gi];
        end
    endgenerate
    assign r_packed[15*WIDTH +: WIDTH] = r_fmt;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = LOAD;
            LOAD:    state_next = CALC;
            CALC:    if (k_reg == 4'd15) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_dec4) begin
        if (rst_dec4) begin
            state_reg <= IDLE;
            k_reg     <= 4'd0;
            w_out_reg <= '0;
            for (int e = 0; e < 16; e++) begin
                w_reg[e] <= '0;
                g_reg[e] <= '0;
            end
            for (int e = 0; e < 15; e++)
                r_reg[e] <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start) begin
                for (int e = 0; e < 16; e++) begin
                    w_reg[e] <= w_in[e*WIDTH +: WIDTH];
                    g_reg[e] <= g_in[e*WIDTH +: WIDTH];
                end
            end
            if (state_reg == LOAD)
                k_reg <= 4'd0;
            else if (state_reg == CALC)
                k_reg <= k_reg + 4'd1;
            if (state_reg == CALC) begin
                for (int e = 0; e < 15; e++)
                    if (k_reg == 4'(e))
                        r_reg[e] <= r_fmt;
                if (k_reg == 4'd15)
                    w_out_reg <= r_packed;
            end
        end
    end

    assign busy  = (state_reg == LOAD) || (state_reg == CALC);
    assign done  = (state_reg == DONE);
    assign w_out = w_out_reg;

endmodule

// File: tb/tb_symm_decorr4.sv
// Directed and random checks for symm_decorr4; honours SYMM_DECORR4_SAT_EN when defined.
module tb_symm_decorr4;

    localparam int W = 26;

    logic            clk_dec4 = 1'b0;
    logic            rst_dec4;
    logic            start;
    logic [16*W-1:0] w_in;
    logic [16*W-1:0] g_in;
    logic            busy;
    logic            done;
    logic [16*W-1:0] w_out;
`ifdef SYMM_DECORR4_SAT_EN
    logic            sat_flag;
`endif

    symm_decorr4 #(.WIDTH(26), .FRAC(13)) dut (
        .clk_dec4 (clk_dec4),
        .rst_dec4 (rst_dec4),
        .start    (start),
        .w_in     (w_in),
        .g_in     (g_in),
        .busy     (busy),
        .done     (done),
`ifdef SYMM_DECORR4_SAT_EN
        .sat_flag (sat_flag),
`endif
        .w_out    (w_out)
    );

    always #5 clk_dec4 = ~clk_dec4;

    int     n_cmp = 0;
    int     n_err = 0;
    longint wm [16];
    longint gm [16];
    longint em [16];

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [16*W-1:0] pack(input longint m [16]);
        logic [16*W-1:0] p;
        p = '0;
        for (int e = 0; e < 16; e++) p[e*W +: W] = m[e][W-1:0];
        return p;
    endfunction

    function automatic longint elem(input int e);
        return longint'($signed(w_out[e*W +: W]));
    endfunction

    // Diagonal matrix helper: d on the diagonal, 0 elsewhere
    task automatic set_diag(output longint m [16], input longint d);
        for (int e = 0; e < 16; e++) m[e] = (e / 4 == e % 4) ? d : 0;
    endtask

    task automatic check_matrix(input string name, input longint exp [16]);
        for (int e = 0; e < 16; e++)
            check_val($sformatf("%s_w[%0d]", name, e), elem(e), exp[e]);
    endtask

    // Launch one run and measure the cycle (LOAD = 1) in which done appears
    task automatic run(input string name);
        int lat;
        w_in = pack(wm);
        g_in = pack(gm);
        @(negedge clk_dec4); start = 1'b1;
        @(posedge clk_dec4); #1; start = 1'b0;
        check_val({name, "_busy_load"}, longint'(busy), 1);
        lat = 1;
        while (lat < 40 && !done) begin
            @(posedge clk_dec4); #1; lat++;
        end
        check_val({name, "_latency"}, lat, 18);
        check_matrix(name, em);
        @(posedge clk_dec4); #1;
        check_val({name, "_done_pulse"}, longint'(done), 0);
        $display("TXN %s latency=%0d w00=%0d w11=%0d", name, lat, elem(0), elem(5));
    endtask

    // Reference: G from W*W^T >>> 13, then W' = (3W - (G*W >>> 13)) >>> 1 formatted to 26 bits
    task automatic model();
        longint s, t, r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int m = 0; m < 4; m++) s += wm[4*i+m] * wm[4*j+m];
                gm[4*i+j] = s >>> 13;
            end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int m = 0; m < 4; m++) s += gm[4*i+m] * wm[4*m+j];
                t = s >>> 13;
                r = (3 * wm[4*i+j] - t) >>> 1;
`ifdef SYMM_DECORR4_SAT_EN
                if (r > 33554431) r = 33554431;
                if (r < -33554432) r = -33554432;
`else
                r = (r <<< 38) >>> 38;
`endif
                em[4*i+j] = r;
            end
    endtask

    initial begin
        int lat, ndone, first;
        rst_dec4 = 1'b1;
        start    = 1'b0;
        w_in     = '0;
        g_in     = '0;
        repeat (3) @(posedge clk_dec4);
        #1;
        check_val("rst_busy", longint'(busy), 0);
        check_val("rst_done", longint'(done), 0);
        check_val("rst_wout_any", longint'(|w_out), 0);
`ifdef SYMM_DECORR4_SAT_EN
        check_val("rst_sat_flag", longint'(sat_flag), 0);
`endif
        rst_dec4 = 1'b0;
        $display("TXN reset busy=%0d done=%0d", busy, done);

        set_diag(wm, 8192); set_diag(gm, 8192); set_diag(em, 8192);
        run("identity");

        set_diag(wm, 16384); set_diag(gm, 32768); set_diag(em, -8192);
        run("scaled");

        for (int e = 0; e < 16; e++) begin wm[e] = 0; gm[e] = 0; em[e] = 0; end
        wm[0] = 33554431;
`ifdef SYMM_DECORR4_SAT_EN
        em[0] = 33554431;
`else
        em[0] = -16777218;
`endif
        w_in = pack(wm); g_in = pack(gm);
        @(negedge clk_dec4); start = 1'b1;
        @(posedge clk_dec4); #1; start = 1'b0;
        lat = 1;
        while (lat < 40 && !done) begin @(posedge clk_dec4); #1; lat++; end
        check_val("overflow_latency", lat, 18);
        check_val("overflow_w00", elem(0), em[0]);
        check_val("overflow_w01", elem(1), 0);
`ifdef SYMM_DECORR4_SAT_EN
        check_val("overflow_sat_flag", longint'(sat_flag), 1);
`endif
        $display("TXN overflow latency=%0d w00=%0d", lat, elem(0));
        @(posedge clk_dec4); #1;

        set_diag(wm, 8192); set_diag(gm, 8192); set_diag(em, 8192);
        run("identity2");
`ifdef SYMM_DECORR4_SAT_EN
        check_val("identity2_sat_flag", longint'(sat_flag), 0);
`endif

        // start held high throughout; inputs swapped right after the capture edge
        set_diag(wm, 8192); set_diag(gm, 8192);
        w_in = pack(wm); g_in = pack(gm);
        @(negedge clk_dec4); start = 1'b1;
        @(posedge clk_dec4); #1;
        set_diag(wm, 16384); set_diag(gm, 32768);
        w_in = pack(wm); g_in = pack(gm);
        lat = 1; ndone = 0; first = 0;
        repeat (17) begin
            @(posedge clk_dec4); #1; lat++;
            if (done) begin ndone++; if (first == 0) first = lat; end
        end
        start = 1'b0;
        check_val("hold_done_count", ndone, 1);
        check_val("hold_done_cycle", first, 18);
        set_diag(em, 8192);
        check_matrix("hold", em);
        @(posedge clk_dec4); #1;
        check_val("hold_done_pulse", longint'(done), 0);
        $display("TXN hold_start dones=%0d first=%0d", ndone, first);

        // reset during CALC k=5 (sixth cycle after LOAD)
        set_diag(wm, 16384); set_diag(gm, 32768);
        w_in = pack(wm); g_in = pack(gm);
        @(negedge clk_dec4); start = 1'b1;
        @(posedge clk_dec4); #1; start = 1'b0;
        repeat (6) @(posedge clk_dec4);
        #1;
        check_val("midrst_busy_before", longint'(busy), 1);
        rst_dec4 = 1'b1;
        @(posedge clk_dec4); #1;
        rst_dec4 = 1'b0;
        check_val("midrst_busy", longint'(busy), 0);
        check_val("midrst_done", longint'(done), 0);
        check_val("midrst_wout_any", longint'(|w_out), 0);
        ndone = 0;
        repeat (20) begin @(posedge clk_dec4); #1; if (done) ndone++; end
        check_val("midrst_no_done", ndone, 0);
        $display("TXN midreset busy=%0d dones_after=%0d", busy, ndone);
        set_diag(wm, 8192); set_diag(gm, 8192); set_diag(em, 8192);
        run("after_rst");

        for (int n = 0; n < 200; n++) begin
            for (int e = 0; e < 16; e++) begin
                int v;
                v = int'($urandom_range(32766)) - 16383;
                wm[e] = v;
            end
            model();
            run($sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
